// File: rtl/wss_pkg.sv
// Shared types and helpers for the weight stream store.
package wss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n = n + {31'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/wss_if.sv
// Load port, descriptor, stream and statistics signals of the weight stream store.
interface wss_if #(
  parameter int NUM_CH     = 8,
  parameter int BEAT_BYTES = 4,
  parameter int AW         = 32,
  parameter int LW         = 16
);
  logic                           wr_en;
  logic [AW-1:0]                  wr_addr;
  logic [8*BEAT_BYTES-1:0]        wr_data;
  logic [BEAT_BYTES-1:0]          wr_be;
  logic [NUM_CH-1:0]              ch_start;
  logic [NUM_CH*AW-1:0]           ch_base;
  logic [NUM_CH*LW-1:0]           ch_length;
  logic [NUM_CH*LW-1:0]           ch_rows;
  logic [NUM_CH*LW-1:0]           ch_stride;
  logic [NUM_CH-1:0]              ch_busy;
  logic [NUM_CH-1:0]              ch_done;
  logic [NUM_CH-1:0]              out_valid;
  logic [NUM_CH-1:0]              out_ready;
  logic [NUM_CH*8*BEAT_BYTES-1:0] out_data;
  logic [NUM_CH*BEAT_BYTES-1:0]   out_mask;
  logic [NUM_CH-1:0]              out_last;
  logic [NUM_CH-1:0]              err_oob;
  logic [63:0]                    cycle_cnt;
  logic [63:0]                    busy_cnt;
  logic [15:0]                    peak_bw;

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be,
    input  ch_start, ch_base, ch_length, ch_rows, ch_stride, out_ready,
    output ch_busy, ch_done, out_valid, out_data, out_mask, out_last, err_oob,
    output cycle_cnt, busy_cnt, peak_bw
  );

  modport master (
    output wr_en, wr_addr, wr_data, wr_be,
    output ch_start, ch_base, ch_length, ch_rows, ch_stride, out_ready,
    input  ch_busy, ch_done, out_valid, out_data, out_mask, out_last, err_oob,
    input  cycle_cnt, busy_cnt, peak_bw
  );
endinterface

// File: rtl/wss_addr_gen.sv
// Per-channel 2-D strided descriptor walker with a one-deep output slot.
// Issues one read per cycle when the slot is empty or being drained; beat appears 1 cycle later.
module wss_addr_gen
  import wss_pkg::*;
#(
  parameter int BEAT_BYTES = 4,
  parameter int AW         = 32,
  parameter int LW         = 16,
  parameter int MEM_DEPTH  = 262144
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic                  i_start,
  input  logic [AW-1:0]         i_base,
  input  logic [LW-1:0]         i_len,
  input  logic [LW-1:0]         i_rows,
  input  logic [LW-1:0]         i_stride,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_valid,
  output logic [BEAT_BYTES-1:0] o_mask,
  output logic                  o_last,
  output logic                  o_err_oob,
  output logic                  o_rd_en,
  output logic [AW-1:0]         o_rd_addr,
  output logic [BEAT_BYTES-1:0] o_rd_ben
);

  state_t                r_state, w_state_nxt;
  logic [AW-1:0]         r_base;
  logic [LW-1:0]         r_len, r_rows, r_stride, r_row, r_col;
  logic                  r_vld, r_last, r_err;
  logic [BEAT_BYTES-1:0] r_mask;

  logic                  w_hs, w_accept, w_adv, w_row_end, w_final;
  logic [LW:0]           w_col_nxt;
  logic [AW-1:0]         w_addr;
  logic [BEAT_BYTES-1:0] w_mask, w_ben;

  assign w_hs      = r_vld & i_ready;
  assign w_accept  = i_start & (r_state == ST_IDLE);
  assign w_adv     = (r_state == ST_RUN) & (~r_vld | i_ready);
  assign w_col_nxt = {1'b0, r_col} + (LW+1)'(BEAT_BYTES);
  assign w_row_end = w_col_nxt >= {1'b0, r_len};
  assign w_final   = w_row_end & (r_row == (r_rows - LW'(1)));

  // w_ben drops bytes that are masked off or fall outside the array; both read as zero.
  always_comb begin
    w_addr = r_base + AW'(r_row) * AW'(r_stride) + AW'(r_col);
    w_mask = '0;
    w_ben  = '0;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      w_mask[j] = ({1'b0, r_col} + (LW+1)'(j)) < {1'b0, r_len};
      w_ben[j]  = w_mask[j] && ((w_addr + AW'(j)) < AW'(MEM_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start)
          w_state_nxt = ((i_len == '0) || (i_rows == '0)) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if (w_adv && w_final) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        if (w_hs) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      r_base   <= '0;
      r_len    <= '0;
      r_rows   <= '0;
      r_stride <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_vld    <= 1'b0;
      r_last   <= 1'b0;
      r_mask   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_base   <= i_base;
        r_len    <= i_len;
        r_rows   <= i_rows;
        r_stride <= i_stride;
        r_row    <= '0;
        r_col    <= '0;
        r_err    <= 1'b0;
      end
      if (w_adv) begin
        r_vld  <= 1'b1;
        r_mask <= w_mask;
        r_last <= w_final;
        if (|(w_mask & ~w_ben)) r_err <= 1'b1;
        if (w_row_end) begin
          r_col <= '0;
          r_row <= r_row + LW'(1);
        end else begin
          r_col <= w_col_nxt[LW-1:0];
        end
      end else if (w_hs) begin
        r_vld  <= 1'b0;
        r_last <= 1'b0;
        r_mask <= '0;
      end
    end
  end

  assign o_valid   = r_vld;
  assign o_mask    = r_mask;
  assign o_last    = r_last;
  assign o_err_oob = r_err;
  assign o_rd_en   = w_adv;
  assign o_rd_addr = w_addr;
  assign o_rd_ben  = w_ben;

endmodule

// File: rtl/weight_stream_sram.sv
// Byte-addressed weight store with a byte-lane load port and NUM_CH strided read streams.
// Read data is registered (1 cycle); each channel stalls on its own out_ready.
module weight_stream_sram
  import wss_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int MEM_DEPTH  = 262144,
  parameter int BEAT_BYTES = 4,
  parameter int AW         = 32,
  parameter int LW         = 16
) (
  input  logic clk,
  input  logic RSTn,
  wss_if.slave bus
);

  localparam int MAW = $clog2(MEM_DEPTH);

  logic [7:0]                     r_mem [MEM_DEPTH];
  logic [NUM_CH-1:0]              w_busy, w_done, w_valid, w_last, w_err;
  logic [NUM_CH*BEAT_BYTES-1:0]   w_mask;
  logic [NUM_CH*8*BEAT_BYTES-1:0] w_data;
  logic [63:0]                    r_cycle_cnt, r_busy_cnt;
  logic [15:0]                    r_peak_bw, w_bw;

  // Nonblocking write keeps same-cycle reads on the old byte.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      for (int j = 0; j < BEAT_BYTES; j++) begin
        if (bus.wr_be[j] && ((bus.wr_addr + AW'(j)) < AW'(MEM_DEPTH)))
          r_mem[MAW'(bus.wr_addr + AW'(j))] <= bus.wr_data[8*j +: 8];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                    w_rd_en;
    logic [AW-1:0]           w_rd_addr;
    logic [BEAT_BYTES-1:0]   w_rd_ben;
    logic [8*BEAT_BYTES-1:0] r_data;

    wss_addr_gen #(
      .BEAT_BYTES (BEAT_BYTES),
      .AW         (AW),
      .LW         (LW),
      .MEM_DEPTH  (MEM_DEPTH)
    ) u_addr_gen (
      .clk       (clk),
      .RSTn      (RSTn),
      .i_start   (bus.ch_start[c]),
      .i_base    (bus.ch_base[c*AW +: AW]),
      .i_len     (bus.ch_length[c*LW +: LW]),
      .i_rows    (bus.ch_rows[c*LW +: LW]),
      .i_stride  (bus.ch_stride[c*LW +: LW]),
      .i_ready   (bus.out_ready[c]),
      .o_busy    (w_busy[c]),
      .o_done    (w_done[c]),
      .o_valid   (w_valid[c]),
      .o_mask    (w_mask[c*BEAT_BYTES +: BEAT_BYTES]),
      .o_last    (w_last[c]),
      .o_err_oob (w_err[c]),
      .o_rd_en   (w_rd_en),
      .o_rd_addr (w_rd_addr),
      .o_rd_ben  (w_rd_ben)
    );

    always_ff @(posedge clk) begin
      if (!RSTn) begin
        r_data <= '0;
      end else if (w_rd_en) begin
        for (int j = 0; j < BEAT_BYTES; j++)
          r_data[8*j +: 8] <= w_rd_ben[j] ? r_mem[MAW'(w_rd_addr + AW'(j))] : 8'h00;
      end
    end

    assign w_data[c*8*BEAT_BYTES +: 8*BEAT_BYTES] = r_data;
  end

  assign w_bw = 16'(popcount(32'(w_valid & bus.out_ready)) * 32'(BEAT_BYTES));

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      r_cycle_cnt <= '0;
      r_busy_cnt  <= '0;
      r_peak_bw   <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 64'd1;
      if (|w_busy) r_busy_cnt <= r_busy_cnt + 64'd1;
      if (w_bw > r_peak_bw) r_peak_bw <= w_bw;
    end
  end

  assign bus.ch_busy   = w_busy;
  assign bus.ch_done   = w_done;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_data;
  assign bus.out_mask  = w_mask;
  assign bus.out_last  = w_last;
  assign bus.err_oob   = w_err;
  assign bus.cycle_cnt = r_cycle_cnt;
  assign bus.busy_cnt  = r_busy_cnt;
  assign bus.peak_bw   = r_peak_bw;

endmodule

// File: tb/tb_weight_stream_sram.sv
// Scoreboard bench: descriptors are expanded into expected beats from a byte-array model.
module tb_weight_stream_sram;

  localparam int NUM_CH = 8;
  localparam int MD     = 262144;
  localparam int BB     = 4;
  localparam int AW     = 32;
  localparam int LW     = 16;
  localparam int MAW    = $clog2(MD);

  typedef struct packed {
    logic [8*BB-1:0] data;
    logic [BB-1:0]   mask;
    logic            last;
  } beat_t;

  logic clk;
  logic RSTn;

  wss_if #(.NUM_CH(NUM_CH), .BEAT_BYTES(BB), .AW(AW), .LW(LW)) bus ();

  weight_stream_sram #(
    .NUM_CH(NUM_CH), .MEM_DEPTH(MD), .BEAT_BYTES(BB), .AW(AW), .LW(LW)
  ) dut (
    .clk  (clk),
    .RSTn (RSTn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned tb_cyc = 0;

  logic [7:0]        mmem [MD];
  beat_t             exp_q [NUM_CH][$];
  int                done_exp [NUM_CH];
  bit                has_beats [NUM_CH];
  int unsigned       last_hs_cyc [NUM_CH];
  int                beats_seen [NUM_CH];
  int                nbeats [NUM_CH];
  logic [NUM_CH-1:0] err_exp = '0;
  logic [NUM_CH-1:0] fix_rdy = '1;
  logic [NUM_CH-1:0] rnd_en = '0;
  logic [NUM_CH-1:0] pat_en = '0;
  logic [3:0]        rdy_pat = 4'b1001;

  always @(posedge clk) tb_cyc++;

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NUM_CH; c++)
      bus.out_ready[c] = pat_en[c] ? rdy_pat[tb_cyc[1:0]]
                       : (rnd_en[c] ? 1'($urandom_range(0, 1)) : fix_rdy[c]);
  end

  // Monitor: pops expected beats on handshakes, checks stall stability and done pulses.
  beat_t             cur, e;
  beat_t             hold_b [NUM_CH];
  logic [NUM_CH-1:0] hold_v = '0;

  always @(negedge clk) begin
    if (!RSTn) begin
      hold_v = '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cur.data = bus.out_data[c*8*BB +: 8*BB];
        cur.mask = bus.out_mask[c*BB +: BB];
        cur.last = bus.out_last[c];
        if (hold_v[c]) begin
          n_chk++;
          if (!bus.out_valid[c] || cur !== hold_b[c]) begin
            n_fail++;
            $display("FAIL hold ch%0d: got v=%0b %0h expected v=1 %0h", c, bus.out_valid[c], cur, hold_b[c]);
          end
        end
        if (bus.out_valid[c] && bus.out_ready[c]) begin
          n_chk++;
          if (exp_q[c].size() == 0) begin
            n_fail++;
            $display("FAIL beat_extra ch%0d: got %0h expected no beat", c, cur);
          end else begin
            e = exp_q[c].pop_front();
            beats_seen[c]++;
            if (cur !== e) begin
              n_fail++;
              $display("FAIL beat ch%0d: got data=%h mask=%b last=%b expected data=%h mask=%b last=%b",
                       c, cur.data, cur.mask, cur.last, e.data, e.mask, e.last);
            end
            if (e.last) last_hs_cyc[c] = tb_cyc;
          end
        end
        hold_v[c] = bus.out_valid[c] && !bus.out_ready[c];
        hold_b[c] = cur;
        if (bus.ch_done[c]) begin
          n_chk++;
          if (done_exp[c] == 0) begin
            n_fail++;
            $display("FAIL done_unexpected ch%0d: got 1 expected 0", c);
          end else begin
            done_exp[c]--;
            if (exp_q[c].size() != 0) begin
              n_fail++;
              $display("FAIL done_early ch%0d: got %0d beats left expected 0", c, exp_q[c].size());
            end else if (has_beats[c] && tb_cyc != last_hs_cyc[c] + 1) begin
              n_fail++;
              $display("FAIL done_timing ch%0d: got cycle %0d expected %0d", c, tb_cyc, last_hs_cyc[c] + 1);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] a;
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    bus.wr_be   = be;
    tick();
    bus.wr_en = 1'b0;
    for (int j = 0; j < BB; j++) begin
      a = addr + 32'(j);
      if (be[j] && a < MD) mmem[a[MAW-1:0]] = data[8*j +: 8];
    end
  endtask

  // Expands a descriptor into beats straight from the addressing rules and raises ch_start.
  task automatic prep_desc(input int c, input logic [31:0] base, input int len, input int rows, input int stride);
    int   nb;
    logic oob;
    nb  = 0;
    oob = 1'b0;
    for (int r = 0; r < rows && len > 0; r++) begin
      for (int col = 0; col < len; col += BB) begin
        beat_t       b;
        logic [31:0] a;
        b = '0;
        for (int j = 0; j < BB; j++) begin
          a = base + 32'(r * stride) + 32'(col + j);
          if (col + j < len) begin
            b.mask[j] = 1'b1;
            if (a < MD) b.data[8*j +: 8] = mmem[a[MAW-1:0]];
            else oob = 1'b1;
          end
        end
        b.last = (r == rows - 1) && (col + BB >= len);
        exp_q[c].push_back(b);
        nb++;
      end
    end
    done_exp[c]++;
    has_beats[c] = (nb > 0);
    nbeats[c]    = nb;
    err_exp[c]   = oob;
    bus.ch_start[c]              = 1'b1;
    bus.ch_base[c*AW +: AW]      = base;
    bus.ch_length[c*LW +: LW]    = LW'(len);
    bus.ch_rows[c*LW +: LW]      = LW'(rows);
    bus.ch_stride[c*LW +: LW]    = LW'(stride);
  endtask

  task automatic run_desc(input int c, input logic [31:0] base, input int len, input int rows, input int stride);
    prep_desc(c, base, len, rows, stride);
    tick();
    bus.ch_start = '0;
  endtask

  function automatic bit pending();
    for (int c = 0; c < NUM_CH; c++)
      if (exp_q[c].size() != 0 || done_exp[c] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_quiet(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((pending() || bus.ch_busy != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    n_chk++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d cycles expected < %0d", name, n, budget);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  256'(bus.ch_busy), '0);
    chk({tag, "_done"},  256'(bus.ch_done), '0);
    chk({tag, "_valid"}, 256'(bus.out_valid), '0);
    chk({tag, "_data"},  256'(bus.out_data), '0);
    chk({tag, "_mask"},  256'(bus.out_mask), '0);
    chk({tag, "_last"},  256'(bus.out_last), '0);
    chk({tag, "_err"},   256'(bus.err_oob), '0);
    chk({tag, "_cyc"},   256'(bus.cycle_cnt), '0);
    chk({tag, "_bcnt"},  256'(bus.busy_cnt), '0);
    chk({tag, "_peak"},  256'(bus.peak_bw), '0);
  endtask

  initial begin
    logic [63:0] s0;
    int          mx;
    RSTn = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    bus.ch_start = '0; bus.ch_base = '0; bus.ch_length = '0; bus.ch_rows = '0; bus.ch_stride = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      done_exp[c] = 0; has_beats[c] = 0; last_hs_cyc[c] = 0; beats_seen[c] = 0; nbeats[c] = 0;
    end
    repeat (3) tick();
    chk_zero("reset");
    RSTn = 1'b1;

    for (int a = 0; a < 1024; a += 4) begin
      logic [31:0] d;
      if (a < 64) d = {8'(a + 3), 8'(a + 2), 8'(a + 1), 8'(a)};
      else d = $urandom;
      do_write(32'(a), d, 4'hF);
    end
    do_write(32'(MD - 8), $urandom, 4'hF);
    do_write(32'(MD - 4), $urandom, 4'hF);
    do_write(32'(MD - 2), $urandom, 4'hF);
    for (int k = 0; k < 40; k++)
      do_write(32'($urandom_range(64, 1019)), $urandom, 4'($urandom_range(0, 15)));

    @(negedge clk);
    s0 = bus.cycle_cnt;
    repeat (10) @(negedge clk);
    chk("cycle_cnt_delta", 256'(bus.cycle_cnt - s0), 256'(10));

    run_desc(0, 32'd0, 8, 2, 16);
    wait_quiet("t1", 200);

    run_desc(2, 32'h40, 6, 2, 20);
    run_desc(6, 32'd0, 0, 3, 4);
    run_desc(7, 32'd0, 5, 0, 4);
    wait_quiet("t2", 200);

    pat_en[1] = 1'b1;
    beats_seen[1] = 0;
    run_desc(1, 32'h20, 8, 2, 32);
    wait_quiet("t3", 200);
    chk("t3_beats", 256'(beats_seen[1]), 256'(4));
    pat_en[1] = 1'b0;

    run_desc(0, 32'd0, 8, 1, 8);
    tick();
    do_write(32'd4, 32'h0000AA00, 4'b0010);
    wait_quiet("t4a", 200);
    run_desc(0, 32'd0, 8, 1, 8);
    wait_quiet("t4b", 200);

    s0 = bus.busy_cnt;
    mx = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      prep_desc(c, 32'(c * 16), 4 * (c + 1), 2 + c % 3, 48);
      if (nbeats[c] > mx) mx = nbeats[c];
    end
    tick();
    bus.ch_start = '0;
    wait_quiet("t5", 500);
    chk("t5_peak_bw", 256'(bus.peak_bw), 256'(NUM_CH * BB));
    chk("t5_busy_cnt", 256'(bus.busy_cnt - s0), 256'(mx + 1));
    chk("t5_err", 256'(bus.err_oob), 256'(err_exp));

    rnd_en = '1;
    run_desc(3, 32'h100, 16, 4, 24);
    tick();
    bus.ch_start[3] = 1'b1;
    bus.ch_base[3*AW +: AW] = 32'h200;
    bus.ch_length[3*LW +: LW] = LW'(4);
    tick();
    bus.ch_start = '0;
    wait_quiet("ignored_start", 1000);

    for (int round = 0; round < 6; round++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        int len, rows;
        len  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
        rows = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
        run_desc(c, 32'($urandom_range(0, 300)), len, rows, $urandom_range(0, 100));
      end
      wait_quiet("random", 5000);
      chk("random_err", 256'(bus.err_oob), 256'(err_exp));
    end
    rnd_en = '0;

    run_desc(4, 32'(MD - 2), 4, 1, 4);
    wait_quiet("t6_oob", 200);
    chk("t6_err_set", 256'(bus.err_oob), 256'(err_exp));
    chk("t6_err_bit", 256'(bus.err_oob[4]), 256'(1));
    run_desc(4, 32'd0, 4, 1, 4);
    wait_quiet("t6_clr", 200);
    chk("t6_err_clr", 256'(bus.err_oob), 256'(0));

    fix_rdy[5] = 1'b0;
    run_desc(5, 32'd0, 16, 4, 16);
    repeat (4) tick();
    RSTn = 1'b0;
    tick();
    for (int c = 0; c < NUM_CH; c++) begin
      exp_q[c].delete();
      done_exp[c] = 0;
    end
    err_exp = '0;
    chk_zero("midrst");
    RSTn = 1'b1;
    fix_rdy = '1;
    repeat (20) tick();
    chk("midrst_idle", 256'(bus.ch_busy), 256'(0));
    run_desc(5, 32'd0, 16, 2, 16);
    wait_quiet("retain", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
